// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: in-order speculative store buffer with commit/discard, flush,
// program-order drain port and combinational store-to-load forwarding.
module store_buffer_fwd #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [ADDR_W-1:0] alloc_addr_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    input  logic [BE_W-1:0]   alloc_be_i,
    output logic [IDX_W-1:0]  alloc_idx_o,
    input  logic              commit_i,
    input  logic [IDX_W-1:0]  commit_idx_i,
    input  logic              discard_i,
    input  logic [IDX_W-1:0]  discard_idx_i,
    input  logic              flush_i,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic [DATA_W-1:0] drain_data_o,
    output logic [BE_W-1:0]   drain_be_o,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    input  logic [BE_W-1:0]   fwd_be_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              fwd_partial_o,
    output logic [IDX_W:0]    count_o,
    output logic              empty_o
);
    localparam int OFF = $clog2(BE_W);

    typedef enum logic [1:0] {FREE, PENDING, COMMITTED, DISCARDED} state_t;

    state_t            r_st [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [BE_W-1:0]   r_be [DEPTH];
    logic [IDX_W-1:0]  r_head, r_tail;
    logic [IDX_W:0]    r_count;

    state_t            w_st_nxt [DEPTH];
    logic              w_full, w_alloc, w_drain_valid, w_retire;
    logic [IDX_W-1:0]  w_k;
    logic              w_match, w_cover;
    logic [DATA_W-1:0] w_fdata;
    logic [BE_W-1:0]   w_fbe;
    logic              w_unused;

    // No bypass: a full buffer refuses allocation even while the head retires.
    assign w_full        = r_count == (IDX_W + 1)'(DEPTH);
    assign alloc_ready_o = rstn_i && !w_full && !flush_i;
    assign w_alloc       = alloc_valid_i && alloc_ready_o;
    assign alloc_idx_o   = rstn_i ? r_tail : '0;
    assign w_drain_valid = rstn_i && r_st[r_head] == COMMITTED;
    assign w_retire      = rstn_i && (r_st[r_head] == DISCARDED || (w_drain_valid && drain_ready_i));
    assign drain_valid_o = w_drain_valid;
    assign drain_addr_o  = w_drain_valid ? r_addr[r_head] : '0;
    assign drain_data_o  = w_drain_valid ? r_data[r_head] : '0;
    assign drain_be_o    = w_drain_valid ? r_be[r_head] : '0;
    assign count_o       = rstn_i ? r_count : '0;
    assign empty_o       = rstn_i && r_count == '0;
    assign w_unused      = ^fwd_addr_i;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_st_nxt[i] = (w_alloc && r_tail == IDX_W'(i)) ? PENDING
                        : (w_retire && r_head == IDX_W'(i)) ? FREE
                        : ((r_st[i] == PENDING && flush_i) ||
                           (r_st[i] inside {PENDING, COMMITTED} && discard_i && discard_idx_i == IDX_W'(i))) ? DISCARDED
                        : (r_st[i] == PENDING && commit_i && commit_idx_i == IDX_W'(i)) ? COMMITTED
                        : r_st[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_st[i] <= FREE;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_st[i] <= w_st_nxt[i];
            if (w_alloc) begin
                r_addr[r_tail] <= alloc_addr_i;
                r_data[r_tail] <= alloc_data_i;
                r_be[r_tail]   <= alloc_be_i;
            end
            r_head  <= r_head + IDX_W'(w_retire);
            r_tail  <= r_tail + IDX_W'(w_alloc);
            r_count <= r_count + (IDX_W + 1)'(w_alloc) - (IDX_W + 1)'(w_retire);
        end
    end

    // Walk oldest to youngest so the last overlapping live entry wins.
    always_comb begin
        w_k     = r_head;
        w_match = 1'b0;
        w_fdata = '0;
        w_fbe   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_k = r_head + IDX_W'(i);
            if (r_st[w_k] inside {PENDING, COMMITTED} &&
                r_addr[w_k][ADDR_W-1:OFF] == fwd_addr_i[ADDR_W-1:OFF] &&
                |(r_be[w_k] & fwd_be_i)) begin
                w_match = 1'b1;
                w_fdata = r_data[w_k];
                w_fbe   = r_be[w_k];
            end
        end
    end

    assign w_cover       = (w_fbe & fwd_be_i) == fwd_be_i;
    assign fwd_hit_o     = rstn_i && w_match && w_cover;
    assign fwd_partial_o = rstn_i && w_match && !w_cover;
    assign fwd_data_o    = (rstn_i && w_match) ? w_fdata : '0;
endmodule
